// File: rtl/fb_pkg.sv
// fb_pkg: shared types and constants for the
// frame-buffer write path.
package fb_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 3;

  localparam logic [2:0] RED   = 3'b100;
  localparam logic [2:0] GREEN = 3'b010;
  localparam logic [2:0] BLUE  = 3'b001;
  localparam logic [2:0] BLACK = 3'b000;

  typedef enum logic {
    ST_IDLE,
    ST_FILL
  } state_t;

  typedef enum logic {
    TURN_FILL,
    TURN_PX
  } turn_t;

endpackage

// File: rtl/fb_fill_counter.sv
// fb_fill_counter: fill address counter with
// clear, enable and an all-ones flag.
module fb_fill_counter #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [AW-1:0] cnt,
  output logic          is_last
);

  // address counter; the end of a fill is found
  // by the all-ones compare, not by wrap-around
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign is_last = &cnt;

endmodule

// File: rtl/fb_write_scheduler.sv
// fb_write_scheduler: shares the frame-buffer
// write port between a fill engine and a pixel port.
module fb_write_scheduler
  import fb_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter bit BLANK_ONLY = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fill_start,
  input  logic [DW-1:0] fill_color,
  output logic          fill_busy,
  output logic          fill_done,
  input  logic          px_valid,
  input  logic [AW-1:0] px_addr,
  input  logic [DW-1:0] px_data,
  output logic          px_ready,
  input  logic          vblank,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_data,
  output logic          ram_we
);

  state_t        state, state_n;
  turn_t         turn, turn_n;
  logic [DW-1:0] color;
  logic [AW-1:0] fill_cnt;
  logic          is_last;
  logic          gate;
  logic          px_wr;
  logic          fill_wr;
  logic          cnt_clr;
  logic          latch;

  assign gate      = ~BLANK_ONLY | vblank;
  assign fill_busy = (state == ST_FILL);

  fb_fill_counter #(
    .AW (AW)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (cnt_clr),
    .en      (fill_wr),
    .cnt     (fill_cnt),
    .is_last (is_last)
  );

  // arbitration: pick at most one writer per cycle
  always_comb begin
    state_n  = state;
    turn_n   = turn;
    px_ready = 1'b0;
    px_wr    = 1'b0;
    fill_wr  = 1'b0;
    cnt_clr  = 1'b0;
    latch    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        px_ready = gate;
        px_wr    = px_valid & gate;
        if (fill_start) begin
          state_n = ST_FILL;
          turn_n  = TURN_FILL;
          cnt_clr = 1'b1;
          latch   = 1'b1;
        end
      end
      ST_FILL: begin
        px_ready = gate & (turn == TURN_PX);
        px_wr    = px_valid & px_ready;
        fill_wr  = gate &
                   ((turn == TURN_FILL) | ~px_valid);
        if (px_wr) begin
          turn_n = TURN_FILL;
        end
        if (fill_wr) begin
          turn_n = px_valid ? TURN_PX : TURN_FILL;
          if (is_last) begin
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // state, turn and latched fill colour
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      turn  <= TURN_FILL;
      color <= '0;
    end else begin
      state <= state_n;
      turn  <= turn_n;
      if (latch) begin
        color <= fill_color;
      end
    end
  end

  // registered write port; address/data hold when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_data  <= '0;
      fill_done <= 1'b0;
    end else begin
      ram_we    <= px_wr | fill_wr;
      fill_done <= fill_wr & is_last;
      if (px_wr) begin
        ram_addr <= px_addr;
        ram_data <= px_data;
      end else if (fill_wr) begin
        ram_addr <= fill_cnt;
        ram_data <= color;
      end
    end
  end

endmodule

// File: tb/tb_fb_write_scheduler.sv
// tb_fb_write_scheduler: scoreboard bench, one
// instance with free writes, one vblank-gated.
module tb_fb_write_scheduler;
  import fb_pkg::*;

  typedef struct {
    int         cyc;
    logic [7:0] a;
    logic [2:0] d;
    logic       done;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  exp_t q0[$];
  exp_t q1[$];

  logic       fs0, pv0, busy0, done0, rdy0, we0;
  logic [2:0] fc0, pd0, data0;
  logic [7:0] pa0, addr0;
  logic       fs1, pv1, busy1, done1, rdy1, we1, vb1;
  logic [2:0] fc1, pd1, data1;
  logic [7:0] pa1, addr1;
  logic       vb0;

  fb_write_scheduler #(
    .AW(8), .DW(3), .BLANK_ONLY(1'b0)
  ) dut0 (
    .clk        (clk),
    .rst        (rst),
    .fill_start (fs0),
    .fill_color (fc0),
    .fill_busy  (busy0),
    .fill_done  (done0),
    .px_valid   (pv0),
    .px_addr    (pa0),
    .px_data    (pd0),
    .px_ready   (rdy0),
    .vblank     (vb0),
    .ram_addr   (addr0),
    .ram_data   (data0),
    .ram_we     (we0)
  );

  fb_write_scheduler #(
    .AW(8), .DW(3), .BLANK_ONLY(1'b1)
  ) dut1 (
    .clk        (clk),
    .rst        (rst),
    .fill_start (fs1),
    .fill_color (fc1),
    .fill_busy  (busy1),
    .fill_done  (done1),
    .px_valid   (pv1),
    .px_addr    (pa1),
    .px_data    (pd1),
    .px_ready   (rdy1),
    .vblank     (vb1),
    .ram_addr   (addr1),
    .ram_data   (data1),
    .ram_we     (we1)
  );

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (we0) begin
        checks++;
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL dut0_write: got addr %0h data %0h, expected none, cycle %0d",
                   addr0, data0, cyc);
        end else begin
          e = q0.pop_front();
          if (e.cyc != cyc || e.a != addr0 ||
              e.d != data0 || e.done != done0) begin
            errors++;
            $display("FAIL dut0_write: got cyc %0d addr %0h data %0h done %0b, expected cyc %0d addr %0h data %0h done %0b",
                     cyc, addr0, data0, done0,
                     e.cyc, e.a, e.d, e.done);
          end
        end
      end else if (done0) begin
        checks++;
        errors++;
        $display("FAIL dut0_done: got done without write, cycle %0d", cyc);
      end else if (q0.size() > 0 && q0[0].cyc <= cyc) begin
        checks++;
        errors++;
        e = q0.pop_front();
        $display("FAIL dut0_write: got no write, expected addr %0h cycle %0d",
                 e.a, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (we1) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL dut1_write: got addr %0h data %0h, expected none, cycle %0d",
                   addr1, data1, cyc);
        end else begin
          e = q1.pop_front();
          if (e.cyc != cyc || e.a != addr1 ||
              e.d != data1 || e.done != done1) begin
            errors++;
            $display("FAIL dut1_write: got cyc %0d addr %0h data %0h done %0b, expected cyc %0d addr %0h data %0h done %0b",
                     cyc, addr1, data1, done1,
                     e.cyc, e.a, e.d, e.done);
          end
        end
      end else if (done1) begin
        checks++;
        errors++;
        $display("FAIL dut1_done: got done without write, cycle %0d", cyc);
      end else if (q1.size() > 0 && q1[0].cyc <= cyc) begin
        checks++;
        errors++;
        e = q1.pop_front();
        $display("FAIL dut1_write: got no write, expected addr %0h cycle %0d",
                 e.a, e.cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int n;
    int kl;
    fs0 = 0; fc0 = 0; pv0 = 0; pa0 = 0; pd0 = 0;
    fs1 = 0; fc1 = 0; pv1 = 0; pa1 = 0; pd1 = 0;
    vb0 = 0; vb1 = 0;
    #1;
    chk("rst_we", we0, 0);
    chk("rst_addr", addr0, 0);
    chk("rst_data", data0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_rdy0", rdy0, 1);
    chk("rst_rdy1", rdy1, 0);
    tick(2);
    rst = 0;
    tick(1);

    // pixel write from IDLE
    c = cyc;
    pv0 = 1; pa0 = 8'h12; pd0 = RED;
    chk("idle_rdy", rdy0, 1);
    q0.push_back('{c + 1, 8'h12, RED, 1'b0});
    tick();
    pv0 = 0;
    tick(3);

    // full fill, blue, second fill_start ignored
    c = cyc;
    fs0 = 1; fc0 = BLUE;
    for (int i = 0; i < 256; i++)
      q0.push_back('{c + 2 + i, 8'(i), BLUE, (i == 255)});
    tick();
    fs0 = 0;
    chk("fill_busy", busy0, 1);
    tick();
    fs0 = 1; fc0 = 3'b111;
    tick(8);
    fs0 = 0;
    tick(246);
    chk("busy_last", busy0, 1);
    tick();
    chk("busy_end", busy0, 0);
    tick(3);
    chk("drain_b", q0.size(), 0);

    // fill_start with px_valid, px held high
    c = cyc;
    fs0 = 1; fc0 = RED;
    pv0 = 1; pa0 = 8'h80; pd0 = GREEN;
    chk("both_rdy", rdy0, 1);
    for (int j = 0; j <= 512; j++) begin
      if (j % 2 == 0)
        q0.push_back('{c + 1 + j, 8'h80, GREEN, 1'b0});
      else
        q0.push_back('{c + 1 + j, 8'((j - 1) / 2), RED,
                       ((j - 1) / 2 == 255)});
    end
    tick();
    fs0 = 0;
    chk("alt_rdy0", rdy0, 0);
    tick();
    chk("alt_rdy1", rdy0, 1);
    tick(511);
    pv0 = 0;
    tick(3);
    chk("drain_c", q0.size(), 0);

    // reset mid-fill, then restart from 0
    c = cyc;
    fs0 = 1; fc0 = 3'b111;
    for (int i = 0; i < 63; i++)
      q0.push_back('{c + 2 + i, 8'(i), 3'b111, 1'b0});
    tick();
    fs0 = 0;
    tick(64);
    rst = 1;
    #1;
    chk("mid_we", we0, 0);
    chk("mid_busy", busy0, 0);
    chk("mid_done", done0, 0);
    chk("mid_addr", addr0, 0);
    tick(2);
    rst = 0;
    tick();
    c = cyc;
    fs0 = 1; fc0 = BLUE;
    for (int i = 0; i < 256; i++)
      q0.push_back('{c + 2 + i, 8'(i), BLUE, (i == 255)});
    tick();
    fs0 = 0;
    tick(260);
    chk("drain_d", q0.size(), 0);

    // vblank-gated instance: pixel waits for vblank
    pv1 = 1; pa1 = 8'h33; pd1 = RED; vb1 = 0;
    #1;
    chk("gate_rdy0", rdy1, 0);
    tick();
    chk("gate_rdy0b", rdy1, 0);
    vb1 = 1;
    #1;
    chk("gate_rdy1", rdy1, 1);
    q1.push_back('{cyc + 1, 8'h33, RED, 1'b0});
    tick();
    pv1 = 0; vb1 = 0;
    tick(2);

    // gated fill: 10 cycles on, 20 off
    c = cyc;
    fs1 = 1; fc1 = GREEN; vb1 = 1;
    n = 0;
    kl = c;
    for (int k = c + 1; n < 256; k++) begin
      if (((k - c) % 30) < 10) begin
        q1.push_back('{k + 1, 8'(n), GREEN, (n == 255)});
        n++;
        kl = k;
      end
    end
    tick();
    fs1 = 0;
    while (cyc <= kl + 2) begin
      vb1 = (((cyc - c) % 30) < 10);
      tick();
    end
    vb1 = 0;
    tick(3);
    chk("drain_e", q1.size(), 0);
    chk("gate_busy", busy1, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
